// File: rtl/fir_pkg.sv
// Shared helpers for the parametrised FIR: width arithmetic and output saturation.
package fir_pkg;

    // Widest intermediate the saturation helper works on.
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Accumulator width that can hold the sum of all products without wrapping.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + clog2(taps);
    endfunction

    // Clamp a sign-extended value to the signed range of out_w bits.
    function automatic sat_t sat_clamp(input logic signed [SAT_W-1:0] v,
                                       input int unsigned out_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end else begin
            r.ovf = 1'b0;
            r.val = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational post-processing of the accumulator: round half up, arithmetic shift, clamp.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned ACC_W = 18,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    ovf
);

    localparam int unsigned HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    // Rounding constant 2^(SHIFT-1); zero when no shift is applied.
    localparam logic [ACC_W:0] HALF = (SHIFT > 0) ? ((ACC_W + 1)'(1) << HALF_POS) : '0;

    // One guard bit so adding the rounding constant can never wrap.
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   shf;
    logic signed [SAT_W-1:0] wide;
    sat_t                    sat;
    logic                    unused_sat;

    // Round, shift, sign-extend and clamp.
    always_comb begin
        rnd  = {acc[ACC_W-1], acc} + HALF;
        shf  = rnd >>> SHIFT;
        wide = SAT_W'(shf);
        sat  = sat_clamp(wide, OUT_W);
        y    = sat.val[OUT_W-1:0];
        ovf  = sat.ovf;
    end

    // Upper bits are a copy of the sign after clamping.
    assign unused_sat = ^sat.val[SAT_W-1:OUT_W];

endmodule

// File: rtl/fir_filter_param.sv
// Pipelined direct-form FIR with valid handshake, loadable coefficients,
// rounding shift, output saturation and delay-line flush.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 4,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  x,
    input  logic                      flush,
    input  logic                      coef_wr,
    input  logic [clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic                      out_valid,
    output logic signed [OUT_W-1:0]   y,
    output logic                      ovf
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    logic signed [DATA_W-1:0] d_q [TAPS];
    logic signed [COEF_W-1:0] c_q [TAPS];
    logic signed [PROD_W-1:0] p_q [TAPS];
    logic                     vd_q;
    logic                     v1_q;

    logic signed [ACC_W-1:0]  acc;
    logic signed [OUT_W-1:0]  y_d;
    logic                     ovf_d;
    logic signed [OUT_W-1:0]  y_q;
    logic                     ovf_q;
    logic                     out_valid_q;

    // Stage-2 results are committed only for live samples not killed by flush.
    logic                     s2_fire;
    assign s2_fire = v1_q && !flush;

    // Delay line: shifts on accepted samples, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
            vd_q <= 1'b0;
        end else if (in_valid) begin
            d_q[0] <= x;
            for (int unsigned k = 1; k < TAPS; k++) begin
                d_q[k] <= d_q[k-1];
            end
            vd_q <= 1'b1;
        end else begin
            vd_q <= 1'b0;
        end
    end

    // Coefficient file: resets to pass-through, out-of-range addresses are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                c_q[k] <= (k == 0) ? COEF_W'(1) : '0;
            end
        end else if (coef_wr && (32'(coef_addr) < TAPS)) begin
            c_q[coef_addr] <= coef_data;
        end
    end

    // Stage 1: per-tap products, captured only when the delay line holds a new sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                p_q[k] <= '0;
            end
            v1_q <= 1'b0;
        end else begin
            v1_q <= vd_q && !flush;
            if (vd_q) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    p_q[k] <= d_q[k] * c_q[k];
                end
            end
        end
    end

    // Stage 2 adder tree, sign-extending every product to the full accumulator width.
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(p_q[k]);
        end
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc (acc),
        .y   (y_d),
        .ovf (ovf_d)
    );

    // Output registers: y holds between samples, ovf only accompanies out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s2_fire;
            ovf_q       <= s2_fire && ovf_d;
            if (s2_fire) begin
                y_q <= y_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_fir_filter_param;

    localparam int TAPS  = 4;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic signed [7:0] x;
    logic              flush;
    logic              coef_wr;
    logic [1:0]        coef_addr;
    logic signed [7:0] coef_data;

    logic               out_valid0, out_valid1;
    logic signed [15:0] y0, y1;
    logic               ovf0, ovf1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fir_filter_param #(.SHIFT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .flush     (flush),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid0),
        .y         (y0),
        .ovf       (ovf0)
    );

    fir_filter_param #(.SHIFT(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .flush     (flush),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid1),
        .y         (y1),
        .ovf       (ovf1)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    longint hist [TAPS];
    longint coef [TAPS];
    longint snap [TAPS];
    bit     s1_v, s2_v;
    longint s2_y [2];
    bit     s2_o [2];
    bit     e_v;
    longint e_y  [2];
    bit     e_o  [2];

    function automatic void ref_out(input longint acc, input int sh,
                                    output longint yv, output bit ov);
        if (sh > 0) acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
        ov = 1'b1;
        if (acc > MAXV) yv = MAXV;
        else if (acc < MINV) yv = MINV;
        else begin yv = acc; ov = 1'b0; end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                hist[k] = 0;
                coef[k] = (k == 0) ? 1 : 0;
            end
            s1_v = 0; s2_v = 0; e_v = 0;
            for (int j = 0; j < 2; j++) begin e_y[j] = 0; e_o[j] = 0; end
        end else begin
            // output of the sample accepted two edges ago
            e_v = s2_v && !flush;
            for (int j = 0; j < 2; j++) begin
                if (e_v) e_y[j] = s2_y[j];
                e_o[j] = e_v && s2_o[j];
            end
            // products for the sample accepted one edge ago use the coefficients in force now
            s2_v = s1_v && !flush;
            begin
                longint acc;
                acc = 0;
                for (int k = 0; k < TAPS; k++) acc += snap[k] * coef[k];
                ref_out(acc, 0, s2_y[0], s2_o[0]);
                ref_out(acc, 2, s2_y[1], s2_o[1]);
            end
            if (coef_wr) coef[coef_addr] = longint'(coef_data);
            if (flush) begin
                for (int k = 0; k < TAPS; k++) hist[k] = 0;
                s1_v = 0;
            end else if (in_valid) begin
                for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = longint'(x);
                for (int k = 0; k < TAPS; k++) snap[k] = hist[k];
                s1_v = 1;
            end else begin
                s1_v = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    longint cap0[$], cap1[$];
    bit     capo0[$], capo1[$];
    longint exp_q[$];
    bit     expo_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
        check("vld0", out_valid0, e_v);
        check("y0",   y0,         e_y[0]);
        check("ovf0", ovf0,       e_o[0]);
        check("vld1", out_valid1, e_v);
        check("y1",   y1,         e_y[1]);
        check("ovf1", ovf1,       e_o[1]);
        if (out_valid0) begin cap0.push_back(longint'(y0)); capo0.push_back(ovf0); end
        if (out_valid1) begin cap1.push_back(longint'(y1)); capo1.push_back(ovf1); end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        x        = 8'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_wr   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 8'(v);
        tick();
        coef_wr   = 1'b0;
    endtask

    task automatic load_all(input int c0, input int c1, input int c2, input int c3);
        wr_coef(0, c0); wr_coef(1, c1); wr_coef(2, c2); wr_coef(3, c3);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic clear_caps();
        cap0.delete(); cap1.delete(); capo0.delete(); capo1.delete();
    endtask

    // Compare the captured outputs of one DUT with exp_q / expo_q.
    task automatic check_cap(input string tag, input int which);
        longint gy[$];
        bit     go[$];
        if (which == 0) begin gy = cap0; go = capo0; end
        else begin gy = cap1; go = capo1; end
        check({tag, "_count"}, gy.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < gy.size(); i++) begin
            check($sformatf("%s_y%0d", tag, i), gy[i], exp_q[i]);
            check($sformatf("%s_ovf%0d", tag, i), go[i], expo_q[i]);
        end
        clear_caps();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; flush = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        idle(2);
        rst = 1'b0;
        check("rst_y",   y0, 0);
        check("rst_vld", out_valid0, 0);
        check("rst_ovf", ovf0, 0);

        // 1: pass-through defaults
        clear_caps();
        send(5); send(-3); send(7); idle(3);
        exp_q = '{5, -3, 7}; expo_q = '{0, 0, 0};
        check_cap("t1", 0);

        // 2: moving sum
        load_all(1, 1, 1, 1); do_flush(); idle(2); clear_caps();
        send(1); send(2); send(3); send(4); send(0); send(0); idle(3);
        exp_q = '{1, 3, 6, 10, 9, 7}; expo_q = '{0, 0, 0, 0, 0, 0};
        check_cap("t2", 0);

        // 3: impulse response, back-to-back then with gaps
        load_all(1, 2, 3, 4); do_flush(); idle(2); clear_caps();
        send(1); send(0); send(0); send(0); idle(3);
        exp_q = '{1, 2, 3, 4}; expo_q = '{0, 0, 0, 0};
        check_cap("t3a", 0);
        do_flush(); idle(2); clear_caps();
        send(1); idle(2); send(0); idle(1); send(0); idle(3); send(0); idle(4);
        check_cap("t3b", 0);

        // 4: saturation both ways
        load_all(-128, -128, -128, -128); do_flush(); idle(2); clear_caps();
        repeat (4) send(-128);
        idle(3);
        exp_q = '{16384, 32767, 32767, 32767}; expo_q = '{0, 1, 1, 1};
        check_cap("t4p", 0);
        load_all(127, 127, 127, 127); do_flush(); idle(2); clear_caps();
        repeat (4) send(-128);
        idle(3);
        exp_q = '{-16256, -32512, -32768, -32768}; expo_q = '{0, 0, 1, 1};
        check_cap("t4n", 0);

        // 5: rounding shift on the SHIFT=2 instance
        load_all(1, 0, 0, 0); do_flush(); idle(2); clear_caps();
        send(6); idle(3); do_flush();
        send(-6); idle(3); do_flush();
        send(5); idle(3);
        exp_q = '{2, -1, 1}; expo_q = '{0, 0, 0};
        check_cap("t5", 1);

        // 6: flush drops the in-flight sample, then reset mid-stream
        load_all(1, 1, 1, 1); do_flush(); idle(2); clear_caps();
        send(1); idle(1); send(2); do_flush(); send(3); idle(3);
        exp_q = '{1, 3}; expo_q = '{0, 0};
        check_cap("t6f", 0);
        send(5); send(6);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_vld", out_valid0, 0);
        check("t6_rst_y", y0, 0);
        idle(3); clear_caps();
        send(9); send(4); idle(3);
        exp_q = '{9, 4}; expo_q = '{0, 0};
        check_cap("t6r", 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            x         = 8'($urandom_range(0, 255));
            flush     = ($urandom_range(0, 29) == 0);
            coef_wr   = ($urandom_range(0, 9) == 0);
            coef_addr = 2'($urandom_range(0, 3));
            r         = $urandom_range(0, 3);
            coef_data = (r == 0) ? 8'sh80 : (r == 1) ? 8'sh7f : 8'($urandom_range(0, 255));
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; coef_wr = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
